// File: rtl/tft_pkg.sv
// Shared definitions for the TFT bus arbiter: arbiter state encoding,
// TFT byte width and default requester count.
package tft_pkg;

  localparam int TFT_BYTE_W    = 8;
  localparam int TFT_N_REQ_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/tft_arb_picker.sv
// Requester selection: returns the first set req bit searching upward from
// pointer+1 with wrap; pointer = N_REQ-1 yields plain fixed priority (0 first).
module tft_arb_picker
  import tft_pkg::*;
#(
  parameter int N_REQ = TFT_N_REQ_DEF,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N_REQ-1:0] pick
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N_REQ) ? s - N_REQ : s;
  endfunction

  // Walk from farthest to nearest candidate so the nearest match is written last.
  always_comb begin
    pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (wrap_idx(int'(pointer), k) == i)) begin
          pick    = '0;
          pick[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tft_bus_arbiter.sv
// Shares one SPI transmitter among N_REQ TFT requesters with non-preemptive
// ownership and a drain phase; define TFT_ARB_ROUND_ROBIN_EN for round robin.
module tft_bus_arbiter
  import tft_pkg::*;
#(
  parameter int N_REQ = TFT_N_REQ_DEF,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [TFT_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]            req_dc,
  input  logic [N_REQ-1:0]            req_transmit,
  input  logic                        spi_busy,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            req_busy,
  output logic [TFT_BYTE_W-1:0]       spi_data,
  output logic                        spi_dc,
  output logic                        spi_transmit,
  output logic [CNT_W-1:0]            byte_count,
  output logic                        err
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_pick;
  logic [PTR_W-1:0] w_ptr;
  logic [CNT_W-1:0] r_byte_count;
  logic             r_err;
  logic             w_start;
  logic             w_release;
  logic             w_violation;

  assign w_start   = (r_state == IDLE) && (|req);
  assign w_release = (r_state == OWN) && !(|(req & r_grant));

  tft_arb_picker #(.N_REQ(N_REQ)) u_picker (
    .req     (req),
    .pointer (w_ptr),
    .pick    (w_pick)
  );

`ifdef TFT_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_pick_idx;

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= PTR_W'(N_REQ - 1);
    else if (w_start) r_ptr <= w_pick_idx;
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = PTR_W'(N_REQ - 1);
`endif

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values,
  // so ordering between always_ff blocks cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path leaves w_state_nxt unassigned
  // (otherwise a latch is inferred).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = OWN;
      OWN:     if (w_release) w_state_nxt = spi_busy ? DRAIN : IDLE;
      DRAIN:   if (!spi_busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    req_busy     = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) req_busy[i] = spi_busy;
      if ((r_state == OWN) && r_grant[i]) begin
        spi_data     = req_data[i*TFT_BYTE_W +: TFT_BYTE_W];
        spi_dc       = req_dc[i];
        spi_transmit = req_transmit[i];
      end
    end
  end

  // Grant falls on the release edge itself; DRAIN runs with grant already 0.
  always_ff @(posedge clk) begin
    if (rst)            r_grant <= '0;
    else if (w_start)   r_grant <= w_pick;
    else if (w_release) r_grant <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) r_byte_count <= '0;
    else if (spi_transmit && (r_byte_count != '1))
      r_byte_count <= r_byte_count + CNT_W'(1);
  end

  assign w_violation = (|(req_transmit & ~r_grant)) || (spi_transmit && spi_busy);

  always_ff @(posedge clk) begin
    if (rst)              r_err <= 1'b0;
    else if (w_violation) r_err <= 1'b1;
  end

  assign grant      = r_grant;
  assign byte_count = r_byte_count;
  assign err        = r_err;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Scoreboard bench for tft_bus_arbiter: a transaction-level model predicts
// every cycle's outputs into a queue that an independent monitor drains.
module tb_tft_bus_arbiter;
  import tft_pkg::*;

  localparam int N       = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req, req_dc, req_transmit;
  logic [8*N-1:0]   req_data;
  logic             spi_busy;
  logic [N-1:0]     grant, req_busy;
  logic [7:0]       spi_data;
  logic             spi_dc, spi_transmit;
  logic [CNT_W-1:0] byte_count;
  logic             err;

  tft_bus_arbiter #(.N_REQ(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_dc       (req_dc),
    .req_transmit (req_transmit),
    .spi_busy     (spi_busy),
    .grant        (grant),
    .req_busy     (req_busy),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_transmit (spi_transmit),
    .byte_count   (byte_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]     grant;
    logic [N-1:0]     busy;
    logic [7:0]       data;
    logic             dc;
    logic             tx;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: who owns the bus, whether a release is still draining,
  // bytes counted this grant, sticky error, last granted index.
  int m_owner;
  bit m_drain;
  int m_cnt;
  bit m_err;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_drain = 1'b0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_ptr   = N - 1;
  endtask

  function automatic int pick_model(input logic [N-1:0] r);
`ifdef TFT_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (((r >> j) & 1) != 0) return j;
    end
`else
    for (int j = 0; j < N; j++) begin
      if (((r >> j) & 1) != 0) return j;
    end
`endif
    return -1;
  endfunction

  // Drive one cycle, queue the outputs the model predicts for it, then
  // advance the model across the following rising edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] tx,
                      input logic b, input logic rs);
    exp_t e;
    @(negedge clk);
    req          = r;
    req_transmit = tx;
    spi_busy     = b;
    rst          = rs;
    req_data     = (8*N)'($urandom());
    req_dc       = N'($urandom());

    e.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.busy  = b ? '1 : ~e.grant;
    e.data  = '0;
    e.dc    = 1'b0;
    e.tx    = 1'b0;
    if (m_owner >= 0) begin
      e.data = 8'(req_data >> (8 * m_owner));
      e.dc   = ((req_dc >> m_owner) & 1) != 0;
      e.tx   = ((tx >> m_owner) & 1) != 0;
    end
    e.cnt = CNT_W'(m_cnt);
    e.err = m_err;
    sb_q.push_back(e);

    if (rs) begin
      model_reset();
    end else begin
      if (((tx & ~e.grant) != 0) || (e.tx && b)) m_err = 1'b1;
      if (e.tx && (m_cnt < CNT_MAX)) m_cnt++;
      if (m_owner >= 0) begin
        if (((r >> m_owner) & 1) == 0) begin
          m_owner = -1;
          m_drain = b;
        end
      end else if (m_drain) begin
        if (!b) m_drain = 1'b0;
      end else if (r != 0) begin
        m_owner = pick_model(r);
        m_cnt   = 0;
        m_ptr   = m_owner;
      end
    end
  endtask

  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        me = sb_q.pop_front();
        check("grant",        grant,        me.grant);
        check("req_busy",     req_busy,     me.busy);
        check("spi_data",     spi_data,     me.data);
        check("spi_dc",       spi_dc,       me.dc);
        check("spi_transmit", spi_transmit, me.tx);
        check("byte_count",   byte_count,   me.cnt);
        check("err",          err,          me.err);
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] r;
    logic [N-1:0] tx;
    logic         b;
    logic         rs;
    logic [N-1:0] rr_seq [4];

    rst = 1'b1; req = '0; req_transmit = '0; req_dc = '0; req_data = '0; spi_busy = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state and fixed-priority pick with no preemption
    step(3'b000, 3'b000, 1'b0, 1'b0);
    #2 check("rst_grant", grant, 3'b000);
    check("rst_req_busy", req_busy, 3'b111);
    step(3'b110, 3'b000, 1'b0, 1'b0);
    step(3'b110, 3'b000, 1'b0, 1'b0);
    #2 check("prio_grant", grant, 3'b010);
    step(3'b100, 3'b000, 1'b0, 1'b0);
    #2 check("fall_cycle_grant", grant, 3'b010);
    step(3'b100, 3'b000, 1'b0, 1'b0);
    #2 check("idle_gap_grant", grant, 3'b000);
    step(3'b100, 3'b000, 1'b0, 1'b0);
    #2 check("next_grant", grant, 3'b100);

    // Drain: three bytes, release while busy, stray strobes masked
    step(3'b000, 3'b000, 1'b0, 1'b1);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    repeat (3) step(3'b001, 3'b001, 1'b0, 1'b0);
    step(3'b000, 3'b000, 1'b1, 1'b0);
    repeat (4) begin
      step(3'b010, 3'b001, 1'b1, 1'b0);
      #2 check("drain_grant", grant, 3'b000);
      check("drain_tx", spi_transmit, 1'b0);
      check("drain_count", byte_count, 4'd3);
    end
    step(3'b010, 3'b000, 1'b0, 1'b0);
    step(3'b010, 3'b000, 1'b0, 1'b0);
    #2 check("post_drain_idle", grant, 3'b000);
    step(3'b010, 3'b000, 1'b0, 1'b0);
    #2 check("post_drain_grant", grant, 3'b010);
    check("new_grant_count", byte_count, 4'd0);

    // Protocol violation: strobe from a requester without grant
    step(3'b000, 3'b000, 1'b0, 1'b1);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    #2 check("viol_grant", grant, 3'b001);
    step(3'b001, 3'b100, 1'b0, 1'b0);
    #2 check("viol_tx", spi_transmit, 1'b0);
    check("viol_err_pre", err, 1'b0);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    #2 check("viol_err_set", err, 1'b1);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 1'b0);
    #2 check("viol_err_sticky", err, 1'b1);

    // Reset mid-transaction while busy
    step(3'b000, 3'b000, 1'b0, 1'b1);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    step(3'b001, 3'b001, 1'b0, 1'b0);
    step(3'b001, 3'b000, 1'b1, 1'b1);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    #2 check("rst_mid_grant", grant, 3'b000);
    check("rst_mid_count", byte_count, 4'd0);
    check("rst_mid_busy", req_busy, 3'b111);
    check("rst_mid_err", err, 1'b0);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    #2 check("rst_mid_regrant", grant, 3'b001);

    // Counter saturation
    step(3'b000, 3'b000, 1'b0, 1'b1);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    repeat (20) step(3'b001, 3'b001, 1'b0, 1'b0);
    step(3'b001, 3'b000, 1'b0, 1'b0);
    #2 check("sat_count", byte_count, 4'd15);

`ifdef TFT_ARB_ROUND_ROBIN_EN
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    step(3'b000, 3'b000, 1'b0, 1'b1);
    step(3'b111, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(3'b111, rr_seq[k], 1'b0, 1'b0);
      #2 check("rr_grant", grant, rr_seq[k]);
      step(3'b111 & ~rr_seq[k], 3'b000, 1'b0, 1'b0);
      step(3'b111, 3'b000, 1'b0, 1'b0);
    end
`else
    rr_seq = '{3'b000, 3'b000, 3'b000, 3'b000};
`endif

    // Randomized traffic against the model
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      b  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 149) == 0);
      tx = '0;
      for (int i = 0; i < N; i++) begin
        if (i == m_owner) begin
          if ($urandom_range(0, 5) == 0) r[i] = 1'b0;
          if (!b && $urandom_range(0, 1) == 1) tx[i] = 1'b1;
          if (b && $urandom_range(0, 49) == 0) tx[i] = 1'b1;
        end else if (!r[i]) begin
          if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
        end else if ($urandom_range(0, 19) == 0) begin
          r[i] = 1'b0;
        end
        if ($urandom_range(0, 149) == 0) tx[i] = 1'b1;
      end
      step(r, tx, b, rs);
    end

    step('0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #4 check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
